// File: rtl/divergent_reconvergence_stack_pkg.sv
// Shared constants for the SIMT reconvergence stack: per-warp FSM state encoding.
package divergent_reconvergence_stack_pkg;

    typedef logic [2:0] state_t;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_READY    = 3'd1;
    localparam logic [2:0] ST_WAIT_DEC = 3'd2;
    localparam logic [2:0] ST_POP      = 3'd3;
    localparam logic [2:0] ST_ERROR    = 3'd4;

endpackage

// File: rtl/divergent_reconvergence_stack_warp.sv
// One warp's reconvergence stack: FSM, entry storage and TOS pointer.
// Divergence pushes not-taken then taken entries so the taken path runs first.
module warp_reconvergence_stack
    import divergent_reconvergence_stack_pkg::*;
#(
    parameter int PcWidth    = 32,
    parameter int WarpWidth  = 32,
    parameter int StackDepth = 11
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 init,
    input  logic [PcWidth-1:0]   init_pc,
    input  logic                 fetch,
    input  logic                 dec,
    input  logic                 dec_is_branch,
    input  logic [PcWidth-1:0]   dec_next_pc,
    input  logic [PcWidth-1:0]   dec_target_pc,
    input  logic [PcWidth-1:0]   dec_reconv_pc,
    input  logic [WarpWidth-1:0] dec_taken_mask,
    output logic                 ready,
    output logic [PcWidth-1:0]   tos_pc,
    output logic [WarpWidth-1:0] tos_mask,
    output logic                 overflow
);

    localparam int PtrWidth = $clog2(StackDepth);
    localparam logic [PtrWidth:0] MaxPtr = (PtrWidth + 1)'(StackDepth - 1);

    typedef struct packed {
        logic [PcWidth-1:0]   pc;
        logic [WarpWidth-1:0] act_mask;
        logic [PcWidth-1:0]   reconv_pc;
    } entry_t;

    state_t              state_q;
    logic [PtrWidth-1:0] ptr_q;
    entry_t              stack_q [StackDepth];

    entry_t               tos;
    logic [WarpWidth-1:0] taken;
    logic [PcWidth-1:0]   cand_pc;
    logic                 uniform;
    logic                 pop_hit;
    logic                 room;
    logic                 tos_at_reconv;
    logic [PtrWidth-1:0]  ptr_up1;
    logic [PtrWidth-1:0]  ptr_up2;
    logic [PtrWidth-1:0]  ptr_dn;

    assign ptr_up1 = ptr_q + PtrWidth'(1);
    assign ptr_up2 = ptr_q + PtrWidth'(2);
    assign ptr_dn  = ptr_q - PtrWidth'(1);

    always_comb begin
        tos           = stack_q[ptr_q];
        taken         = dec_taken_mask & tos.act_mask;
        uniform       = !dec_is_branch || (taken == '0) || (taken == tos.act_mask);
        cand_pc       = (dec_is_branch && (taken != '0) && (taken == tos.act_mask))
                        ? dec_target_pc : dec_next_pc;
        pop_hit       = (ptr_q != '0) && (cand_pc == tos.reconv_pc);
        room          = ({1'b0, ptr_q} + (PtrWidth + 1)'(2)) <= MaxPtr;
        tos_at_reconv = (ptr_q != '0) && (tos.pc == tos.reconv_pc);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            ptr_q    <= '0;
            overflow <= 1'b0;
            for (int i = 0; i < StackDepth; i++) stack_q[i] <= '0;
        end else if (init) begin
            // init wins over anything else targeting this warp in the same cycle
            state_q    <= ST_READY;
            ptr_q      <= '0;
            overflow   <= 1'b0;
            stack_q[0] <= '{pc: init_pc, act_mask: '1, reconv_pc: '0};
        end else begin
            case (state_q)
                ST_READY: if (fetch) state_q <= ST_WAIT_DEC;
                ST_WAIT_DEC: begin
                    if (dec) begin
                        if (uniform) begin
                            if (pop_hit) begin
                                ptr_q   <= ptr_dn;
                                state_q <= ST_POP;
                            end else begin
                                stack_q[ptr_q].pc <= cand_pc;
                                state_q           <= ST_READY;
                            end
                        end else if (room) begin
                            stack_q[ptr_q].pc <= dec_reconv_pc;
                            stack_q[ptr_up1]  <= '{pc: dec_next_pc, act_mask: tos.act_mask & ~taken,
                                                   reconv_pc: dec_reconv_pc};
                            stack_q[ptr_up2]  <= '{pc: dec_target_pc, act_mask: taken,
                                                   reconv_pc: dec_reconv_pc};
                            ptr_q             <= ptr_up2;
                            state_q           <= ST_READY;
                        end else begin
                            overflow <= 1'b1;
                            state_q  <= ST_ERROR;
                        end
                    end
                end
                // one TOS check per cycle keeps the compare path short
                ST_POP: begin
                    if (tos_at_reconv) ptr_q <= ptr_dn;
                    else state_q <= ST_READY;
                end
                default: ;
            endcase
        end
    end

    assign ready    = (state_q == ST_READY);
    assign tos_pc   = tos.pc;
    assign tos_mask = tos.act_mask;

    a_dec_in_wait: assert property (@(posedge clk) disable iff (rst)
        (dec && !init) |-> (state_q == ST_WAIT_DEC));
    a_fetch_ready: assert property (@(posedge clk) disable iff (rst)
        (fetch && !init) |-> (state_q == ST_READY));

endmodule

// File: rtl/divergent_reconvergence_stack.sv
// Per-warp SIMT reconvergence stacks for a compute unit: demuxes init/fetch/decode
// by warp id and muxes the selected warp's TOS PC and active mask to the fetcher.
module divergent_reconvergence_stack #(
    parameter  int PcWidth    = 32,
    parameter  int WarpWidth  = 32,
    parameter  int NumWarps   = 8,
    parameter  int StackDepth = 2 * $clog2(WarpWidth) + 1,
    localparam int WidWidth   = NumWarps > 1 ? $clog2(NumWarps) : 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 init_i,
    input  logic [WidWidth-1:0]  init_wid_i,
    input  logic [PcWidth-1:0]   init_pc_i,
    output logic [NumWarps-1:0]  ready_for_fetch_o,
    input  logic                 fetch_valid_i,
    input  logic [WidWidth-1:0]  fetch_wid_i,
    output logic [PcWidth-1:0]   fetch_pc_o,
    output logic [WarpWidth-1:0] fetch_act_mask_o,
    input  logic                 dec_valid_i,
    input  logic [WidWidth-1:0]  dec_wid_i,
    input  logic                 dec_is_branch_i,
    input  logic [PcWidth-1:0]   dec_next_pc_i,
    input  logic [PcWidth-1:0]   dec_target_pc_i,
    input  logic [PcWidth-1:0]   dec_reconv_pc_i,
    input  logic [WarpWidth-1:0] dec_taken_mask_i,
    output logic [NumWarps-1:0]  overflow_o
);

    if (StackDepth < 3) begin : g_bad_depth
        $error("divergent_reconvergence_stack: StackDepth must be >= 3");
    end

    logic [NumWarps-1:0][PcWidth-1:0]   tos_pc;
    logic [NumWarps-1:0][WarpWidth-1:0] tos_mask;

    for (genvar w = 0; w < NumWarps; w++) begin : g_warp
        warp_reconvergence_stack #(
            .PcWidth    (PcWidth),
            .WarpWidth  (WarpWidth),
            .StackDepth (StackDepth)
        ) u_warp (
            .clk            (clk_i),
            .rst            (rst_i),
            .init           (init_i && (init_wid_i == WidWidth'(w))),
            .init_pc        (init_pc_i),
            .fetch          (fetch_valid_i && (fetch_wid_i == WidWidth'(w))),
            .dec            (dec_valid_i && (dec_wid_i == WidWidth'(w))),
            .dec_is_branch  (dec_is_branch_i),
            .dec_next_pc    (dec_next_pc_i),
            .dec_target_pc  (dec_target_pc_i),
            .dec_reconv_pc  (dec_reconv_pc_i),
            .dec_taken_mask (dec_taken_mask_i),
            .ready          (ready_for_fetch_o[w]),
            .tos_pc         (tos_pc[w]),
            .tos_mask       (tos_mask[w]),
            .overflow       (overflow_o[w])
        );
    end

    assign fetch_pc_o       = tos_pc[fetch_wid_i];
    assign fetch_act_mask_o = tos_mask[fetch_wid_i];

endmodule

// File: tb/tb_divergent_reconvergence_stack.sv
// Directed bench: 32-thread instance driven from a vector table, 4-thread instance for overflow.
module tb_divergent_reconvergence_stack;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // instance A: 32 threads, 8 warps
    logic        a_init, a_fv, a_dv, a_br;
    logic [2:0]  a_iw, a_fw, a_dw;
    logic [31:0] a_ipc, a_npc, a_tpc, a_rpc, a_tk, a_pc, a_mask;
    logic [7:0]  a_rdy, a_ovf;

    // instance B: 4 threads, 4 warps, depth 5
    logic        b_init, b_fv, b_dv, b_br;
    logic [1:0]  b_iw, b_fw, b_dw;
    logic [31:0] b_ipc, b_npc, b_tpc, b_rpc, b_pc;
    logic [3:0]  b_tk, b_mask, b_rdy, b_ovf;

    divergent_reconvergence_stack #(.PcWidth(32), .WarpWidth(32), .NumWarps(8)) dut_a (
        .clk_i(clk), .rst_i(rst),
        .init_i(a_init), .init_wid_i(a_iw), .init_pc_i(a_ipc),
        .ready_for_fetch_o(a_rdy),
        .fetch_valid_i(a_fv), .fetch_wid_i(a_fw),
        .fetch_pc_o(a_pc), .fetch_act_mask_o(a_mask),
        .dec_valid_i(a_dv), .dec_wid_i(a_dw), .dec_is_branch_i(a_br),
        .dec_next_pc_i(a_npc), .dec_target_pc_i(a_tpc), .dec_reconv_pc_i(a_rpc),
        .dec_taken_mask_i(a_tk),
        .overflow_o(a_ovf)
    );

    divergent_reconvergence_stack #(.PcWidth(32), .WarpWidth(4), .NumWarps(4)) dut_b (
        .clk_i(clk), .rst_i(rst),
        .init_i(b_init), .init_wid_i(b_iw), .init_pc_i(b_ipc),
        .ready_for_fetch_o(b_rdy),
        .fetch_valid_i(b_fv), .fetch_wid_i(b_fw),
        .fetch_pc_o(b_pc), .fetch_act_mask_o(b_mask),
        .dec_valid_i(b_dv), .dec_wid_i(b_dw), .dec_is_branch_i(b_br),
        .dec_next_pc_i(b_npc), .dec_target_pc_i(b_tpc), .dec_reconv_pc_i(b_rpc),
        .dec_taken_mask_i(b_tk),
        .overflow_o(b_ovf)
    );

    typedef struct {
        logic        ini;
        logic [2:0]  iw;
        logic [31:0] ipc;
        logic        fv;
        logic [2:0]  fw;
        logic        dv;
        logic [2:0]  dw;
        logic        br;
        logic [31:0] npc, tpc, rpc, tk;
        logic [7:0]  rdy;
        logic [31:0] pc, mask;
        logic [7:0]  ovf;
    } vec_t;

    int tests = 0;
    int fails = 0;
    vec_t tbl[$];

    localparam logic [31:0] ONES = 32'hFFFF_FFFF;

    function automatic vec_t row(input logic ini, input logic [2:0] iw, input logic [31:0] ipc,
                                 input logic fv, input logic [2:0] fw,
                                 input logic dv, input logic [2:0] dw, input logic br,
                                 input logic [31:0] npc, input logic [31:0] tpc,
                                 input logic [31:0] rpc, input logic [31:0] tk,
                                 input logic [7:0] rdy, input logic [31:0] pc,
                                 input logic [31:0] mask, input logic [7:0] ovf);
        vec_t v;
        v.ini = ini; v.iw = iw; v.ipc = ipc; v.fv = fv; v.fw = fw;
        v.dv = dv; v.dw = dw; v.br = br; v.npc = npc; v.tpc = tpc; v.rpc = rpc; v.tk = tk;
        v.rdy = rdy; v.pc = pc; v.mask = mask; v.ovf = ovf;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic a_idle();
        a_init = 0; a_iw = 0; a_ipc = 0; a_fv = 0; a_fw = 0;
        a_dv = 0; a_dw = 0; a_br = 0; a_npc = 0; a_tpc = 0; a_rpc = 0; a_tk = 0;
    endtask

    // drive one cycle, check pre-edge outputs, then advance past the edge
    task automatic apply(input vec_t v, input string tag);
        a_init = v.ini; a_iw = v.iw; a_ipc = v.ipc; a_fv = v.fv; a_fw = v.fw;
        a_dv = v.dv; a_dw = v.dw; a_br = v.br; a_npc = v.npc; a_tpc = v.tpc;
        a_rpc = v.rpc; a_tk = v.tk;
        #1;
        chk({tag, " ready"}, {24'd0, a_rdy}, {24'd0, v.rdy});
        chk({tag, " pc"},    a_pc,           v.pc);
        chk({tag, " mask"},  a_mask,         v.mask);
        chk({tag, " ovf"},   {24'd0, a_ovf}, {24'd0, v.ovf});
        @(posedge clk); #2;
    endtask

    task automatic b_step(input logic ini, input logic [31:0] ipc, input logic fv,
                          input logic dv, input logic br, input logic [31:0] npc,
                          input logic [31:0] tpc, input logic [31:0] rpc, input logic [3:0] tk,
                          input logic [3:0] erdy, input logic [31:0] epc,
                          input logic [3:0] emask, input logic [3:0] eovf, input string tag);
        b_init = ini; b_iw = 2'd1; b_ipc = ipc; b_fv = fv; b_fw = 2'd1;
        b_dv = dv; b_dw = 2'd1; b_br = br; b_npc = npc; b_tpc = tpc; b_rpc = rpc; b_tk = tk;
        #1;
        chk({tag, " ready"}, {28'd0, b_rdy},  {28'd0, erdy});
        chk({tag, " pc"},    b_pc,            epc);
        chk({tag, " mask"},  {28'd0, b_mask}, {28'd0, emask});
        chk({tag, " ovf"},   {28'd0, b_ovf},  {28'd0, eovf});
        @(posedge clk); #2;
    endtask

    initial begin
        a_idle();
        b_init = 0; b_iw = 0; b_ipc = 0; b_fv = 0; b_fw = 0; b_dv = 0; b_dw = 0;
        b_br = 0; b_npc = 0; b_tpc = 0; b_rpc = 0; b_tk = 0;
        a_fw = 3'd2;

        //          ini iw ipc      fv fw  dv dw br npc      tpc      rpc      tk             rdy    pc        mask           ovf
        tbl.push_back(row(1, 2, 'h100,  0, 2,  0, 0, 0, 0,       0,       0,       0,             'h00, 'h0,     'h0,          0));
        tbl.push_back(row(0, 0, 0,      1, 2,  0, 0, 0, 0,       0,       0,       0,             'h04, 'h100,   ONES,         0));
        tbl.push_back(row(0, 0, 0,      0, 2,  1, 2, 0, 'h104,   0,       0,       0,             'h00, 'h100,   ONES,         0));
        tbl.push_back(row(0, 0, 0,      1, 2,  0, 0, 0, 0,       0,       0,       0,             'h04, 'h104,   ONES,         0));
        tbl.push_back(row(0, 0, 0,      0, 2,  1, 2, 1, 'h108,   'h200,   'h300,   'h0000FFFF,    'h00, 'h104,   ONES,         0));
        tbl.push_back(row(0, 0, 0,      1, 2,  0, 0, 0, 0,       0,       0,       0,             'h04, 'h200,   'h0000FFFF,   0));
        tbl.push_back(row(0, 0, 0,      0, 2,  1, 2, 0, 'h300,   0,       0,       0,             'h00, 'h200,   'h0000FFFF,   0));
        tbl.push_back(row(0, 0, 0,      0, 2,  0, 0, 0, 0,       0,       0,       0,             'h00, 'h108,   'hFFFF0000,   0));
        tbl.push_back(row(0, 0, 0,      1, 2,  0, 0, 0, 0,       0,       0,       0,             'h04, 'h108,   'hFFFF0000,   0));
        tbl.push_back(row(0, 0, 0,      0, 2,  1, 2, 0, 'h300,   0,       0,       0,             'h00, 'h108,   'hFFFF0000,   0));
        tbl.push_back(row(0, 0, 0,      0, 2,  0, 0, 0, 0,       0,       0,       0,             'h00, 'h300,   ONES,         0));
        tbl.push_back(row(0, 0, 0,      1, 2,  0, 0, 0, 0,       0,       0,       0,             'h04, 'h300,   ONES,         0));
        // uniform taken, then uniform not-taken
        tbl.push_back(row(0, 0, 0,      0, 2,  1, 2, 1, 'h304,   'h500,   'h600,   ONES,          'h00, 'h300,   ONES,         0));
        tbl.push_back(row(0, 0, 0,      1, 2,  0, 0, 0, 0,       0,       0,       0,             'h04, 'h500,   ONES,         0));
        tbl.push_back(row(0, 0, 0,      0, 2,  1, 2, 1, 'h504,   'h700,   'h800,   'h0,           'h00, 'h500,   ONES,         0));
        tbl.push_back(row(0, 0, 0,      1, 2,  0, 0, 0, 0,       0,       0,       0,             'h04, 'h504,   ONES,         0));
        // divergence whose fall-through is the reconv point: two chained POP cycles
        tbl.push_back(row(0, 0, 0,      0, 2,  1, 2, 1, 'h300,   'h200,   'h300,   'h0000FFFF,    'h00, 'h504,   ONES,         0));
        tbl.push_back(row(0, 0, 0,      1, 2,  0, 0, 0, 0,       0,       0,       0,             'h04, 'h200,   'h0000FFFF,   0));
        tbl.push_back(row(0, 0, 0,      0, 2,  1, 2, 0, 'h300,   0,       0,       0,             'h00, 'h200,   'h0000FFFF,   0));
        tbl.push_back(row(0, 0, 0,      0, 2,  0, 0, 0, 0,       0,       0,       0,             'h00, 'h300,   'hFFFF0000,   0));
        tbl.push_back(row(0, 0, 0,      0, 2,  0, 0, 0, 0,       0,       0,       0,             'h00, 'h300,   ONES,         0));
        tbl.push_back(row(0, 0, 0,      0, 2,  0, 0, 0, 0,       0,       0,       0,             'h04, 'h300,   ONES,         0));
        // concurrent traffic across warps
        tbl.push_back(row(1, 0, 'h1000, 0, 2,  0, 0, 0, 0,       0,       0,       0,             'h04, 'h300,   ONES,         0));
        tbl.push_back(row(1, 1, 'h2000, 0, 0,  0, 0, 0, 0,       0,       0,       0,             'h05, 'h1000,  ONES,         0));
        tbl.push_back(row(0, 0, 0,      1, 1,  0, 0, 0, 0,       0,       0,       0,             'h07, 'h2000,  ONES,         0));
        tbl.push_back(row(1, 3, 'h3000, 1, 0,  1, 1, 0, 'h2004,  0,       0,       0,             'h05, 'h1000,  ONES,         0));
        tbl.push_back(row(0, 0, 0,      0, 1,  0, 0, 0, 0,       0,       0,       0,             'h0E, 'h2004,  ONES,         0));
        tbl.push_back(row(0, 0, 0,      0, 3,  0, 0, 0, 0,       0,       0,       0,             'h0E, 'h3000,  ONES,         0));
        tbl.push_back(row(0, 0, 0,      0, 0,  1, 0, 0, 'h1004,  0,       0,       0,             'h0E, 'h1000,  ONES,         0));
        tbl.push_back(row(0, 0, 0,      1, 0,  0, 0, 0, 0,       0,       0,       0,             'h0F, 'h1004,  ONES,         0));
        // init overrides a same-cycle decode
        tbl.push_back(row(1, 0, 'h1800, 0, 0,  1, 0, 0, 'h1008,  0,       0,       0,             'h0E, 'h1004,  ONES,         0));
        tbl.push_back(row(0, 0, 0,      0, 0,  0, 0, 0, 0,       0,       0,       0,             'h0F, 'h1800,  ONES,         0));

        // reset state
        #12;
        chk("reset ready A", {24'd0, a_rdy}, 32'd0);
        chk("reset pc A", a_pc, 32'd0);
        chk("reset mask A", a_mask, 32'd0);
        chk("reset ovf A", {24'd0, a_ovf}, 32'd0);
        chk("reset ready B", {28'd0, b_rdy}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #2;

        foreach (tbl[i]) apply(tbl[i], $sformatf("row%0d", i));

        // overflow on the 4-thread instance: third nested divergence has no room
        b_step(1, 'h40,  0, 0, 0, 0,     0,     0,     4'b0000, 4'h0, 'h0,   4'h0, 4'h0, "b0");
        b_step(0, 0,     1, 0, 0, 0,     0,     0,     4'b0000, 4'h2, 'h40,  4'hF, 4'h0, "b1");
        b_step(0, 0,     0, 1, 1, 'h44,  'h80,  'hC0,  4'b0111, 4'h0, 'h40,  4'hF, 4'h0, "b2");
        b_step(0, 0,     1, 0, 0, 0,     0,     0,     4'b0000, 4'h2, 'h80,  4'h7, 4'h0, "b3");
        b_step(0, 0,     0, 1, 1, 'h84,  'h90,  'hA0,  4'b0011, 4'h0, 'h80,  4'h7, 4'h0, "b4");
        b_step(0, 0,     1, 0, 0, 0,     0,     0,     4'b0000, 4'h2, 'h90,  4'h3, 4'h0, "b5");
        b_step(0, 0,     0, 1, 1, 'h94,  'h98,  'h9C,  4'b0001, 4'h0, 'h90,  4'h3, 4'h0, "b6");
        b_step(0, 0,     0, 0, 0, 0,     0,     0,     4'b0000, 4'h0, 'h90,  4'h3, 4'h2, "b7");
        b_step(1, 'h400, 0, 0, 0, 0,     0,     0,     4'b0000, 4'h0, 'h90,  4'h3, 4'h2, "b8");
        b_step(0, 0,     0, 0, 0, 0,     0,     0,     4'b0000, 4'h2, 'h400, 4'hF, 4'h0, "b9");
        b_init = 0; b_fv = 0; b_dv = 0;

        // drive warp 2 into POP, then hit it with an asynchronous reset
        apply(row(0, 0, 0, 1, 2, 0, 0, 0, 0,     0,     0,     0,          'h0F, 'h300, ONES,        0), "pre0");
        apply(row(0, 0, 0, 0, 2, 1, 2, 1, 'h300, 'h200, 'h300, 'h0000FFFF, 'h0B, 'h300, ONES,        0), "pre1");
        apply(row(0, 0, 0, 1, 2, 0, 0, 0, 0,     0,     0,     0,          'h0F, 'h200, 'h0000FFFF,  0), "pre2");
        apply(row(0, 0, 0, 0, 2, 1, 2, 0, 'h300, 0,     0,     0,          'h0B, 'h200, 'h0000FFFF,  0), "pre3");
        a_idle();
        a_fw = 3'd2;
        #1;
        chk("in POP ready", {24'd0, a_rdy}, 32'h0B);
        chk("in POP mask", a_mask, 32'hFFFF0000);
        rst = 1'b1;
        #1;
        chk("async rst ready", {24'd0, a_rdy}, 32'd0);
        chk("async rst pc", a_pc, 32'd0);
        chk("async rst mask", a_mask, 32'd0);
        chk("async rst ovf", {24'd0, a_ovf}, 32'd0);
        chk("async rst ready B", {28'd0, b_rdy}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #2;
        chk("idle after rst", {24'd0, a_rdy}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
